// File: rtl/snes_pad_pkg.sv
// snes_pad_pkg: shared types and constants for the SNES/NES pad responder.
// Contents: FSM state enum, button bit positions in the 12-bit button word,
//           frame lengths, and the shift-register load-word builder.
package snes_pad_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LATCH,
      ST_SHIFT,
      ST_EXHAUSTED
   } state_t;

   // Bit positions inside the button word (1 = pressed).
   localparam int BTN_B      = 0;
   localparam int BTN_Y      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;
   localparam int BTN_A      = 8;
   localparam int BTN_X      = 9;
   localparam int BTN_L      = 10;
   localparam int BTN_R      = 11;

   localparam int SNES_BITS = 16;
   localparam int NES_BITS  = 8;

   // Word loaded into the shift register; bit 0 is the first bit on the wire.
   // NES order on the wire is A,B,Select,Start,Up,Down,Left,Right.
   function automatic logic [15:0] load_word(input logic nes, input logic [11:0] b);
      if (nes)
         return {8'b0, b[BTN_RIGHT], b[BTN_LEFT], b[BTN_DOWN], b[BTN_UP],
                 b[BTN_START], b[BTN_SELECT], b[BTN_B], b[BTN_A]};
      else
         return {4'b0, b[BTN_R], b[BTN_L], b[BTN_X], b[BTN_A],
                 b[BTN_RIGHT], b[BTN_LEFT], b[BTN_DOWN], b[BTN_UP],
                 b[BTN_START], b[BTN_SELECT], b[BTN_Y], b[BTN_B]};
   endfunction

endpackage

// File: rtl/snes_pad_responder_if.sv
// snes_pad_responder_if: pad-side bundle between reader/button source and responder.
// master: drives mode, buttons, strobe_latch, shift_clock; observes data, bit_index, frame_done.
// slave : the responder itself (opposite directions).
interface snes_pad_responder_if;
   logic        mode;
   logic [11:0] buttons;
   logic        strobe_latch;
   logic        shift_clock;
   logic        data;
   logic [4:0]  bit_index;
   logic        frame_done;

   modport master (
      output mode, buttons, strobe_latch, shift_clock,
      input  data, bit_index, frame_done
   );

   modport slave (
      input  mode, buttons, strobe_latch, shift_clock,
      output data, bit_index, frame_done
   );
endinterface

// File: rtl/pin_sync_edge.sv
// pin_sync_edge: STAGES-deep synchronizer for an asynchronous pin plus rise/fall pulses.
// Ports: clk, rst_n (async, active low), pin in; level, rise, fall out (one-cycle flags).
// Latency: level/rise/fall reflect the pin STAGES rising edges after it changes.
module pin_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Reset to the pin's idle level so release of reset never looks like an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], pin};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/snes_pad_responder.sv
// snes_pad_responder: controller-side end of the SNES/NES serial pad protocol.
// Ports: clk, rst_n (async, active low), pad (slave modport: mode, buttons,
//        strobe_latch, shift_clock in; data, bit_index, frame_done out).
// Latency: pin edge to action is SYNC_STAGES+1 clk cycles; data is active low.
module snes_pad_responder
   import snes_pad_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   snes_pad_responder_if.slave  pad
);

   logic latch_lvl, latch_rise, latch_fall;
   logic shift_lvl, shift_rise, shift_fall;

   pin_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_latch_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (pad.strobe_latch),
      .level (latch_lvl),
      .rise  (latch_rise),
      .fall  (latch_fall)
   );

   // Shift clock idles high.
   pin_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_shift_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (pad.shift_clock),
      .level (shift_lvl),
      .rise  (shift_rise),
      .fall  (shift_fall)
   );

   logic unused_edges;
   assign unused_edges = &{1'b0, latch_rise, shift_lvl, shift_fall};

   state_t      state_q, state_d;
   logic [15:0] sr_q, sr_d;
   logic [4:0]  idx_q, idx_d;
   logic        mode_q, mode_d;
   logic        done_q, done_d;
   logic [4:0]  frame_len;
   logic [4:0]  idx_inc;

   assign frame_len = mode_q ? 5'(NES_BITS) : 5'(SNES_BITS);
   assign idx_inc   = idx_q + 5'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         idx_q   <= '0;
         mode_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         idx_q   <= idx_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      idx_d   = idx_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      // A high latch overrides everything, including a coincident shift edge,
      // and aborts any frame in progress without a done pulse.
      if (latch_lvl) begin
         state_d = ST_LATCH;
         sr_d    = load_word(pad.mode, pad.buttons);
         idx_d   = '0;
         mode_d  = pad.mode;
      end else begin
         unique case (state_q)
            ST_LATCH: begin
               // SR and mode keep the values loaded in the last latch-high cycle.
               if (latch_fall)
                  state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
               if (shift_rise) begin
                  sr_d  = {1'b1, sr_q[15:1]};
                  idx_d = idx_inc;
                  if (idx_inc == frame_len) begin
                     state_d = ST_EXHAUSTED;
                     done_d  = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Past the end of the frame the line reads as pressed (fill 1s in SR terms).
   assign pad.data       = (state_q == ST_EXHAUSTED) ? 1'b0 : ~sr_q[0];
   assign pad.bit_index  = idx_q;
   assign pad.frame_done = done_q;

endmodule

// File: tb/tb_snes_pad_responder.sv
// tb_snes_pad_responder: directed vector table plus hand sequences for the pad responder.
module tb_snes_pad_responder;

   logic clk;
   logic rst_n;

   snes_pad_responder_if pad();

   snes_pad_responder #(.SYNC_STAGES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pad   (pad)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int ncmp = 0;
   int nmis = 0;
   int done_total = 0;

   always @(negedge clk)
      if (pad.frame_done === 1'b1) done_total++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        mode;
      logic [11:0] btn;
      int          nclk;
      logic [19:0] exp_bits;   // expected data level seen before rise k
      int          exp_idx;
      int          exp_done;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input int act, input int exp);
      ncmp++;
      if (act != exp) begin
         nmis++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_latch(input logic m, input logic [11:0] b);
      pad.mode         = m;
      pad.buttons      = b;
      pad.strobe_latch = 1'b1;
      cyc(6);
      pad.strobe_latch = 1'b0;
      cyc(6);
   endtask

   // Reader: samples the line after each falling edge, before the next rise.
   task automatic read_bits(input int n, output logic [19:0] got);
      got = '0;
      for (int k = 0; k < n; k++) begin
         pad.shift_clock = 1'b0;
         cyc(6);
         @(negedge clk);
         got[k] = pad.data;
         cyc(1);
         pad.shift_clock = 1'b1;
         cyc(6);
      end
   endtask

   logic [19:0] got;
   int          d0;

   initial begin
      vecs[0] = '{1'b0, 12'h001, 16, 20'h0FFFE, 16, 1};
      vecs[1] = '{1'b0, 12'hFFF, 20, 20'h0F000, 16, 1};
      vecs[2] = '{1'b1, 12'h110,  8, 20'h000EE,  8, 1};
      vecs[3] = '{1'b0, 12'h000, 16, 20'h0FFFF, 16, 1};
      vecs[4] = '{1'b1, 12'hFFF, 10, 20'h00000,  8, 1};
      vecs[5] = '{1'b0, 12'hA5A,  6, 20'h00025,  6, 0};
      vecs[6] = '{1'b1, 12'h0FF,  8, 20'h00001,  8, 1};

      rst_n            = 1'b0;
      pad.mode         = 1'b0;
      pad.buttons      = '0;
      pad.strobe_latch = 1'b0;
      pad.shift_clock  = 1'b1;
      #23;
      check("reset data", int'(pad.data), 1);
      check("reset bit_index", int'(pad.bit_index), 0);
      check("reset frame_done", int'(pad.frame_done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(3);

      // Table-driven frames.
      for (int i = 0; i < 7; i++) begin
         d0 = done_total;
         do_latch(vecs[i].mode, vecs[i].btn);
         read_bits(vecs[i].nclk, got);
         for (int k = 0; k < vecs[i].nclk; k++)
            check($sformatf("v%0d bit%0d", i, k), int'(got[k]), int'(vecs[i].exp_bits[k]));
         @(negedge clk);
         check($sformatf("v%0d bit_index", i), int'(pad.bit_index), vecs[i].exp_idx);
         check($sformatf("v%0d done count", i), done_total - d0, vecs[i].exp_done);
      end

      // Buttons change while latch is high; frame takes the value at latch fall.
      d0 = done_total;
      pad.mode         = 1'b0;
      pad.buttons      = 12'h010;
      pad.strobe_latch = 1'b1;
      cyc(5);
      pad.buttons      = 12'h020;
      cyc(6);
      pad.strobe_latch = 1'b0;
      cyc(6);
      pad.buttons      = 12'h001;
      read_bits(16, got);
      check("latch-window frame", int'(got[15:0]), 16'hFFDF);
      check("latch-window done", done_total - d0, 1);

      // Abort after 5 shifts, with latch and shift rising together.
      d0 = done_total;
      do_latch(1'b0, 12'h003);
      read_bits(5, got);
      check("abort first bits", int'(got[4:0]), 5'h1C);
      @(negedge clk);
      check("abort idx before", int'(pad.bit_index), 5);
      pad.shift_clock = 1'b0;
      cyc(6);
      pad.strobe_latch = 1'b1;
      pad.shift_clock  = 1'b1;
      cyc(6);
      @(negedge clk);
      check("abort idx in latch", int'(pad.bit_index), 0);
      check("abort data in latch", int'(pad.data), 0);
      pad.strobe_latch = 1'b0;
      cyc(6);
      read_bits(16, got);
      check("restart frame", int'(got[15:0]), 16'hFFFC);
      @(negedge clk);
      check("restart idx", int'(pad.bit_index), 16);
      check("abort done count", done_total - d0, 1);

      // Shift-edge to data latency: three clk cycles.
      do_latch(1'b0, 12'h002);
      pad.shift_clock = 1'b0;
      cyc(6);
      @(negedge clk);
      check("latency bit0", int'(pad.data), 1);
      @(posedge clk);
      #1;
      pad.shift_clock = 1'b1;
      repeat (3) @(negedge clk);
      check("latency 2 cycles", int'(pad.data), 1);
      @(negedge clk);
      check("latency 3 cycles", int'(pad.data), 0);
      check("latency idx", int'(pad.bit_index), 1);

      // Asynchronous reset at bit 7.
      d0 = done_total;
      do_latch(1'b0, 12'h080);
      read_bits(7, got);
      @(negedge clk);
      check("pre-reset idx", int'(pad.bit_index), 7);
      check("pre-reset data", int'(pad.data), 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset data", int'(pad.data), 1);
      check("async reset idx", int'(pad.bit_index), 0);
      @(negedge clk);
      rst_n = 1'b1;
      read_bits(3, got);
      @(negedge clk);
      check("post-reset idx", int'(pad.bit_index), 0);
      check("post-reset data", int'(pad.data), 1);
      check("reset done count", done_total - d0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
      $finish;
   end

endmodule
